// File: rtl/scr1_tdp_memory.sv
`default_nettype none
// ============================================================================
// Module   : scr1_tdp_memory
// Purpose  : True dual-port RAM for SCR1 tightly-coupled memories. Both ports
//            read and write with per-byte enables. Read latency (1 or 2) and
//            the cross-port read-during-write result (old or merged data) are
//            parameters. An optional clear walk fills the whole array with
//            INIT_VALUE after reset, before any traffic is accepted.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            a_req/b_req        request strobe
//            a_we/b_we          1 = write, 0 = read
//            a_be/b_be          byte enables for writes
//            a_addr/b_addr      word address
//            a_wdata/b_wdata    write data
//            a_ready/b_ready    port accepts requests (memory in service)
//            a_rvalid/b_rvalid  one-cycle read-data-valid pulse
//            a_rdata/b_rdata    read data, held between pulses
//            init_done          clear walk finished
// Revision : 1.0 - initial release
// ============================================================================
module scr1_tdp_memory #(
  parameter int         SCR1_WIDTH  = 32,
  parameter int         SCR1_SIZE   = 65536,
  parameter int         SCR1_NBYTES = SCR1_WIDTH / 8,
  parameter int         RD_LATENCY  = 1,
  parameter int         WRITE_FIRST = 0,
  parameter int         INIT_CLEAR  = 1,
  parameter logic [7:0] INIT_VALUE  = 8'h00,
  parameter int         AW          = $clog2(SCR1_SIZE) - $clog2(SCR1_NBYTES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   a_req,
  input  logic                   a_we,
  input  logic [SCR1_NBYTES-1:0] a_be,
  input  logic [AW-1:0]          a_addr,
  input  logic [SCR1_WIDTH-1:0]  a_wdata,
  output logic                   a_ready,
  output logic                   a_rvalid,
  output logic [SCR1_WIDTH-1:0]  a_rdata,
  input  logic                   b_req,
  input  logic                   b_we,
  input  logic [SCR1_NBYTES-1:0] b_be,
  input  logic [AW-1:0]          b_addr,
  input  logic [SCR1_WIDTH-1:0]  b_wdata,
  output logic                   b_ready,
  output logic                   b_rvalid,
  output logic [SCR1_WIDTH-1:0]  b_rdata,
  output logic                   init_done
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t ST_RESET = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   cnt;
  logic            run;
  logic            init_wr;
  logic            a_wr;
  logic            b_wr;
  logic [1:0]      rd_acc;
  logic [SCR1_WIDTH-1:0] rd_word  [2];
  logic [1:0]            rvalid_v;
  logic [SCR1_WIDTH-1:0] rdata_v  [2];

  logic [SCR1_WIDTH-1:0] mem [DEPTH];

  // --------------------------------------------------------------------------
  // Service FSM and clear-walk counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RESET;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if ((state == ST_INIT) && (cnt == AW'(DEPTH - 1))) begin
      state_nxt = ST_RUN;
    end
  end

  // With INIT_CLEAR=0 the reset state is already RUN, so reset must also
  // mask the service outputs directly.
  assign run       = (state == ST_RUN) && rst_n;
  assign init_done = run;
  assign a_ready   = run;
  assign b_ready   = run;
  assign init_wr   = (state == ST_INIT) && rst_n;

  assign a_wr      = a_req && run && a_we;
  assign b_wr      = b_req && run && b_we;
  assign rd_acc[0] = a_req && run && !a_we;
  assign rd_acc[1] = b_req && run && !b_we;

  // --------------------------------------------------------------------------
  // Storage. Port B's byte writes are issued after port A's, so on a dual
  // write to the same word the bytes both ports enable take B's data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[cnt] <= {SCR1_NBYTES{INIT_VALUE}};
    end else begin
      for (int i = 0; i < SCR1_NBYTES; i++) begin
        if (a_wr && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        if (b_wr && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  // Word captured on the accept edge. The array read returns pre-write data;
  // in write-first mode the other port's enabled bytes are overlaid.
  always_comb begin
    rd_word[0] = mem[a_addr];
    rd_word[1] = mem[b_addr];
    if (WRITE_FIRST != 0) begin
      for (int i = 0; i < SCR1_NBYTES; i++) begin
        if (b_wr && b_be[i] && (b_addr == a_addr)) rd_word[0][i*8 +: 8] = b_wdata[i*8 +: 8];
        if (a_wr && a_be[i] && (a_addr == b_addr)) rd_word[1][i*8 +: 8] = a_wdata[i*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read pipelines: stage 0 captures on the accept edge, the output register
  // loads RD_LATENCY edges later and holds its data between pulses.
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [RD_LATENCY-1:0] v_pipe;
    logic [SCR1_WIDTH-1:0] d_pipe [RD_LATENCY];
    logic                  out_v;
    logic [SCR1_WIDTH-1:0] out_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_pipe <= '0;
        for (int k = 0; k < RD_LATENCY; k++) d_pipe[k] <= '0;
        out_v  <= 1'b0;
        out_d  <= '0;
      end else begin
        v_pipe[0] <= rd_acc[p];
        if (rd_acc[p]) d_pipe[0] <= rd_word[p];
        for (int k = 1; k < RD_LATENCY; k++) begin
          v_pipe[k] <= v_pipe[k-1];
          d_pipe[k] <= d_pipe[k-1];
        end
        out_v <= v_pipe[RD_LATENCY-1];
        if (v_pipe[RD_LATENCY-1]) out_d <= d_pipe[RD_LATENCY-1];
      end
    end

    assign rvalid_v[p] = out_v;
    assign rdata_v[p]  = out_d;
  end

  assign a_rvalid = rvalid_v[0];
  assign a_rdata  = rdata_v[0];
  assign b_rvalid = rvalid_v[1];
  assign b_rdata  = rdata_v[1];

endmodule
`default_nettype wire
